// File: rtl/score_display_ctrl.sv
`default_nettype none
// score_display_ctrl: sequential binary-to-BCD score converter with a timed ball-number overlay.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in score mode.
module score_display_ctrl #(
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        score_valid,
    input  logic [13:0] score_bin,
    output logic        score_ready,
    input  logic        ball_valid,
    input  logic [3:0]  ball_num,
    output logic        busy,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thous
);
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [13:0]       SCORE_MAX = 14'd9999;
    localparam logic [3:0]        ITER_LAST = 4'd13;
    localparam logic [3:0]        BLANK     = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0]       RESET_DIGITS = 16'hFFF0;
`else
    localparam logic [15:0]       RESET_DIGITS = 16'h0000;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state;
    logic [3:0]          iter;
    logic [29:0]         shift;       // {bcd[15:0], binary[13:0]}
    logic [15:0]         score;
    logic                ov_active;
    logic [HOLD_W-1:0]   hold;
    logic [3:0]          ball;

    logic [15:0]         bcd_adj;
    logic [29:0]         shift_next;
    logic [13:0]         score_sat;
    logic [15:0]         score_digits;

    assign score_sat = (score_bin > SCORE_MAX) ? SCORE_MAX : score_bin;

    // One double-dabble step: add 3 to any digit >= 5, then shift left.
    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < 4; d++) begin
            bcd_adj[d*4 +: 4] = (shift[14 + d*4 +: 4] >= 4'd5) ?
                                shift[14 + d*4 +: 4] + 4'd3 : shift[14 + d*4 +: 4];
        end
        shift_next = {bcd_adj[14:0], shift[13:0], 1'b0};
    end

    always_comb begin
        score_digits = score;
`ifdef LEADING_ZERO_BLANK_EN
        if (score[15:12] == 4'd0) begin
            score_digits[15:12] = BLANK;
            if (score[11:8] == 4'd0) begin
                score_digits[11:8] = BLANK;
                if (score[7:4] == 4'd0) begin
                    score_digits[7:4] = BLANK;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter        <= 4'd0;
            shift       <= '0;
            score       <= 16'd0;
            score_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        state       <= CONV;
                        iter        <= 4'd0;
                        shift       <= {16'd0, score_sat};
                        score_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CONV: begin
                    shift <= shift_next;
                    iter  <= iter + 4'd1;
                    if (iter == ITER_LAST) begin
                        state       <= IDLE;
                        iter        <= 4'd0;
                        score       <= shift_next[29:14];
                        score_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    score_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // A fresh ball_valid always wins over the countdown, restarting the hold window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_active <= 1'b0;
            hold      <= '0;
            ball      <= 4'd0;
        end else if (ball_valid) begin
            ov_active <= 1'b1;
            hold      <= HOLD_LOAD;
            ball      <= ball_num;
        end else if (ov_active) begin
            if (hold == '0) begin
                ov_active <= 1'b0;
            end else begin
                hold <= hold - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {thous, hundreds, tens, ones} <= RESET_DIGITS;
        end else if (ov_active) begin
            {thous, hundreds, tens, ones} <= {BLANK, BLANK, BLANK, ball};
        end else begin
            {thous, hundreds, tens, ones} <= score_digits;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// tb_score_display_ctrl: table vectors, directed corner sequences and random traffic
// checked every cycle against a decimal-arithmetic reference model.
module tb_score_display_ctrl;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        score_valid = 1'b0;
    logic [13:0] score_bin = 14'd0;
    logic        ball_valid = 1'b0;
    logic [3:0]  ball_num = 4'd0;
    logic        score_ready, busy;
    logic [3:0]  ones, tens, hundreds, thous;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_display_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .score_valid(score_valid), .score_bin(score_bin), .score_ready(score_ready),
        .ball_valid(ball_valid), .ball_num(ball_num), .busy(busy),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thous(thous)
    );

    function automatic logic [15:0] digits(int s, bit ov, logic [3:0] b);
        logic [15:0] r;
        if (ov) return {12'hFFF, b};
        r = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`ifdef LEADING_ZERO_BLANK_EN
        if (s < 1000) r[15:12] = 4'hF;
        if (s < 100)  r[11:8]  = 4'hF;
        if (s < 10)   r[7:4]   = 4'hF;
`endif
        return r;
    endfunction

    // Reference model: conversion as a countdown of remaining busy cycles,
    // overlay as remaining visible cycles, display one cycle behind.
    int          m_left, m_score, m_pend, m_ov;
    logic [3:0]  m_ball;
    logic [15:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_score <= 0;
            m_pend  <= 0;
            m_ov    <= 0;
            m_ball  <= 4'd0;
            m_out   <= digits(0, 1'b0, 4'd0);
        end else begin
            m_out <= digits(m_score, m_ov > 0, m_ball);
            if (m_left == 0) begin
                if (score_valid) begin
                    m_left <= 14;
                    m_pend <= (int'(score_bin) > 9999) ? 9999 : int'(score_bin);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_score <= m_pend;
            end
            if (ball_valid) begin
                m_ov   <= HOLD;
                m_ball <= ball_num;
            end else if (m_ov > 0) begin
                m_ov <= m_ov - 1;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("cycle", {14'd0, score_ready, busy, thous, hundreds, tens, ones},
                       {14'd0, m_left == 0, m_left != 0, m_out});
    endtask

    function automatic logic [15:0] shown();
        return {thous, hundreds, tens, ones};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin n++; tick(); end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called at a negedge with the converter idle; returns busy cycle count.
    task automatic do_score(input logic [13:0] v, output int busy_n);
        score_valid = 1'b1;
        score_bin   = v;
        tick();
        score_valid = 1'b0;
        busy_n = 0;
        while (busy && busy_n < 40) begin busy_n++; tick(); end
        tick();
    endtask

    typedef struct {
        logic [13:0] score;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{14'd1234,  16'h1234};
        vecs[1] = '{14'd12000, 16'h9999};
        vecs[2] = '{14'd9999,  16'h9999};
        vecs[3] = '{14'd10000, 16'h9999};
        vecs[4] = '{14'd16383, 16'h9999};
        vecs[5] = '{14'd1000,  16'h1000};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[6] = '{14'd42,  16'hFF42};
        vecs[7] = '{14'd0,   16'hFFF0};
        vecs[8] = '{14'd567, 16'hF567};
        vecs[9] = '{14'd7,   16'hFFF7};
`else
        vecs[6] = '{14'd42,  16'h0042};
        vecs[7] = '{14'd0,   16'h0000};
        vecs[8] = '{14'd567, 16'h0567};
        vecs[9] = '{14'd7,   16'h0007};
`endif

        #1 rst_n = 1'b0;
        tick();
        tick();
        check("reset_state", {14'd0, score_ready, busy, shown()},
                             {14'd0, 1'b1, 1'b0, digits(0, 1'b0, 4'd0)});
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_score(vecs[i].score, n);
            check("busy_cycles", 32'(n), 32'd14);
            check("table_digits", {16'd0, shown()}, {16'd0, vecs[i].exp});
        end

        // Overlay arriving mid-conversion of 567.
        score_valid = 1'b1;
        score_bin   = 14'd567;
        tick();
        score_valid = 1'b0;
        repeat (9) tick();
        ball_valid = 1'b1;
        ball_num   = 4'd3;
        tick();
        ball_valid = 1'b0;
        tick();
        n = 0;
        while (shown() == 16'hFFF3 && n < 40) begin n++; tick(); end
        check("overlay_len", 32'(n), 32'(HOLD));
        check("after_overlay", {16'd0, shown()}, {16'd0, digits(567, 1'b0, 4'd0)});

        // Second ball_valid five cycles in restarts the window; value 12 passes through.
        wait_idle();
        ball_valid = 1'b1;
        ball_num   = 4'd3;
        tick();
        ball_valid = 1'b0;
        repeat (4) tick();
        ball_valid = 1'b1;
        ball_num   = 4'd12;
        tick();
        check("first_overlay", {16'd0, shown()}, 32'h0000FFF3);
        ball_valid = 1'b0;
        tick();
        n = 0;
        while (shown() == 16'hFFFC && n < 40) begin n++; tick(); end
        check("extended_len", 32'(n), 32'(HOLD));
        check("after_extend", {16'd0, shown()}, {16'd0, digits(567, 1'b0, 4'd0)});

        // score_valid held through a conversion: next accept lands at N+15.
        score_valid = 1'b1;
        score_bin   = 14'd100;
        tick();
        check("held_busy_n", 32'(busy), 32'd1);
        score_bin = 14'd200;
        repeat (13) tick();
        check("held_busy_n13", 32'(busy), 32'd1);
        tick();
        check("held_ready_n14", 32'(score_ready), 32'd1);
        tick();
        check("held_accept_n15", 32'(busy), 32'd1);
        score_valid = 1'b0;
        wait_idle();
        tick();
        check("held_digits", {16'd0, shown()}, {16'd0, digits(200, 1'b0, 4'd0)});

        // Reset during iteration 7 of a conversion.
        score_valid = 1'b1;
        score_bin   = 14'd9876;
        tick();
        score_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("rst_flags", {30'd0, score_ready, busy}, 32'd2);
        check("rst_digits", {16'd0, shown()}, {16'd0, digits(0, 1'b0, 4'd0)});
        tick();
        rst_n       = 1'b1;
        score_valid = 1'b1;
        score_bin   = 14'd321;
        tick();
        check("accept_after_rst", 32'(busy), 32'd1);
        score_valid = 1'b0;
        wait_idle();
        tick();
        check("post_rst_digits", {16'd0, shown()}, {16'd0, digits(321, 1'b0, 4'd0)});

        for (int i = 0; i < 3000; i++) begin
            score_valid = ($urandom % 4) == 0;
            score_bin   = 14'($urandom);
            ball_valid  = ($urandom % 30) == 0;
            ball_num    = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
